// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam int unsigned MaxWidth = 32;

  // Magnitude of a width-bit operand; the most-negative value maps to 2^(width-1).
  function automatic logic [MaxWidth-1:0] abs_mag(input logic [MaxWidth-1:0] value,
                                                  input int unsigned       width,
                                                  input logic              signed_mode);
    logic [MaxWidth-1:0] mask;
    mask = {MaxWidth{1'b1}} >> (MaxWidth - width);
    if (signed_mode && value[width-1]) begin
      return (~value + 1'b1) & mask;
    end
    return value & mask;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: scans |a| LSB-first, stops after its highest set bit,
// then applies the sign and publishes the product with a one-cycle done pulse.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [PW-1:0]    b_sh_q, b_sh_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_mag = WIDTH'(abs_mag(32'(a), WIDTH, signed_mode));
  assign b_mag = WIDTH'(abs_mag(32'(b), WIDTH, signed_mode));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    neg_d     = neg_q;
    done_d    = 1'b0;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a_mag;
          b_sh_d  = PW'(b_mag);
          acc_d   = '0;
          neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          state_d = (a_mag != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (a_sh_q[0]) begin
          acc_d = acc_q + b_sh_q;
        end
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q << 1;
        // Early exit once no set multiplier bits remain.
        if (a_sh_d == '0) begin
          state_d = FIN;
        end
      end
      FIN: begin
        product_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      neg_q     <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      neg_q     <= neg_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed and randomised checks of seq_shift_add_multiplier at WIDTH=8.
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int tests_run = 0;
  int tests_failed = 0;

  seq_shift_add_multiplier #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic sm);
    a = av;
    b = bv;
    signed_mode = sm;
    start = 1'b1;
  endtask

  // Clocks the accepting edge, then waits for done and checks latency, product and pulse width.
  // pulse_cyc>0 raises a stray start after that many edges; chain leaves the bench in the done cycle.
  task automatic finish_op(input string tag, input logic [15:0] exp_p, input int exp_lat,
                           input int pulse_cyc, input bit chain);
    int n;
    bit got;
    n = 0;
    got = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~a;
    b = b ^ 8'h5a;
    signed_mode = ~signed_mode;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    while (n < 20 && !got) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (done) begin
        got = 1;
      end else if (n == pulse_cyc) begin
        start = 1'b1;
        a = 8'd3;
        b = 8'd3;
      end
    end
    check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check_eq({tag, "_prod"}, 32'(product), 32'(exp_p));
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    if (!chain) begin
      @(posedge clk);
      #1;
      check_eq({tag, "_pulse"}, 32'(done), 32'd0);
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic sm, input logic [15:0] exp_p, input int exp_lat);
    @(negedge clk);
    launch(av, bv, sm);
    finish_op(tag, exp_p, exp_lat, 0, 1'b0);
  endtask

  function automatic int ref_lat(input logic [7:0] av, input logic sm);
    logic [7:0] m;
    int k;
    m = (sm && av[7]) ? 8'(-av) : av;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) k = i + 1;
    end
    return k + 1;
  endfunction

  function automatic logic [15:0] ref_prod(input logic [7:0] av, input logic [7:0] bv,
                                           input logic sm);
    logic signed [15:0] sp;
    if (sm) begin
      sp = $signed(av) * $signed(bv);
      return sp;
    end
    return 16'(av) * 16'(bv);
  endfunction

  initial begin
    int dones;
    logic [7:0] ra, rb;
    logic rs;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_prod", 32'(product), 32'd0);

    do_op("u13x11", 8'd13, 8'd11, 1'b0, 16'd143, 5);
    repeat (3) @(posedge clk);
    #1;
    check_eq("hold143", 32'(product), 32'd143);

    do_op("zero", 8'd0, 8'd200, 1'b0, 16'd0, 1);
    do_op("one", 8'd1, 8'd255, 1'b0, 16'd255, 2);
    do_op("s_m128sq", 8'h80, 8'h80, 1'b1, 16'h4000, 9);
    do_op("s_m128x127", 8'h80, 8'h7f, 1'b1, 16'hc080, 9);
    do_op("s_m1sq", 8'hff, 8'hff, 1'b1, 16'h0001, 2);
    do_op("s_m3x5", 8'hfd, 8'd5, 1'b1, 16'hfff1, 3);
    do_op("u_msb", 8'h80, 8'h80, 1'b0, 16'h4000, 9);

    // Stray start during RUN is ignored.
    @(negedge clk);
    launch(8'd13, 8'd11, 1'b0);
    finish_op("ign", 16'd143, 5, 2, 1'b0);

    // Start in the done cycle is accepted.
    @(negedge clk);
    launch(8'd6, 8'd7, 1'b0);
    finish_op("b2b_a", 16'd42, 4, 0, 1'b1);
    launch(8'd255, 8'd255, 1'b0);
    finish_op("b2b_b", 16'd65025, 9, 0, 1'b0);

    // Reset mid-RUN aborts without a done pulse.
    @(negedge clk);
    launch(8'd200, 8'd3, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_done", 32'(done), 32'd0);
    check_eq("mrst_prod", 32'(product), 32'd0);
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check_eq("mrst_nodone", 32'(dones), 32'd0);
    do_op("after_rst", 8'd6, 8'd7, 1'b0, 16'd42, 4);

    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op("rnd", ra, rb, rs, ref_prod(ra, rb, rs), ref_lat(ra, rs));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised, iterative shift-add multiplier with a `start`/`busy`/`done` handshake and early termination.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Used by the arithmetic lab datapaths wherever a single-cycle multiplier is too large. The full 2*WIDTH-bit product is held stable between operations.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- signed_mode  input  1  1 = operands are two's complement; sampled with start.
- a  input  WIDTH  multiplier operand; scanned LSB-first; sampled with start.
- b  input  WIDTH  multiplicand operand; sampled with start.
- busy  output  1  high from the cycle after acceptance until done is asserted.
- done  output  1  one-cycle pulse; product valid from the same cycle.
- product  output  2*WIDTH  result register; held until the next completion.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Mid-operation reset aborts the operation.
  - Outputs after reset: state=IDLE, busy=0, done=0, product=0.
  - Internal registers (acc, a_sh, b_sh, neg) are cleared.
- States: IDLE, RUN, FIN. Encoding comes from the package enum.
- IDLE:
  - busy=0.
  - On start=1, load the operands:
    - a_sh = |a| (WIDTH bits unsigned).
    - b_sh = |b|, zero-extended to 2*WIDTH.
    - acc = 0.
    - neg = signed_mode & (a[MSB] ^ b[MSB]).
  - |x| = x when signed_mode=0; otherwise two's-complement magnitude. The most-negative value maps to 2^(WIDTH-1), which fits unsigned.
  - Next state: RUN if |a|≠0, else FIN.
  - start=0: stay in IDLE.
- RUN (busy=1), each cycle:
  - If a_sh[0], then acc <= acc + b_sh, computed at 2*WIDTH bits with no overflow possible.
  - a_sh <= a_sh >> 1; b_sh <= b_sh << 1.
  - Go to FIN when the shifted a_sh equals 0; otherwise stay in RUN.
  - Early termination: the number of RUN cycles is k = index of the highest set bit of |a| + 1, so 1..WIDTH.
- FIN (busy=1):
  - product <= neg ? -acc : acc (2*WIDTH-bit two's complement).
  - done <= 1 for exactly one cycle.
  - Next state: IDLE.
- Latency:
  - Start accepted at edge E0; done and the new product appear after edge E(k+1).
  - Case a=0: done after E1.
  - Worst case: WIDTH+1 cycles.
- start while busy=1 (RUN or FIN): ignored, not queued.
- start in the cycle done=1 (state IDLE): accepted. A back-to-back throughput of one op per k+2 cycles is required.
- product is not cleared on start; it changes only at FIN or reset.
- Inputs a, b and signed_mode may change freely after acceptance without affecting the operation.
- Signed corner cases are exact for WIDTH=8:
  - -128 * -128 = 16384.
  - -128 * 127 = -16256.
- signed_mode=0 with MSB-set operands is treated as plain unsigned.

Decomposition:
- Package mult_pkg:
  - state_t enum {IDLE, RUN, FIN}.
  - Parameterised function abs_mag(value, signed_mode).
  - Localparam PW = 2*WIDTH, derived inside the module.
- No sub-module is needed. The datapath (accumulator, two shift registers, sign flag) and the FSM live in one module. An optional sign fix-up helper can reuse mult_pkg::abs_mag.

Test Plan (WIDTH=8):
- Unsigned: a=13, b=11, signed_mode=0 -> busy for 5 cycles, done pulse after E5, product=143; the value holds after later start=0 cycles.
- Zero/early termination: a=0, b=200 -> done after E1, product=0. Then a=1, b=255 -> done after E2, product=255.
- Signed corners: (-128)*(-128) -> 16'h4000; (-128)*127 -> 16'hC080; (-1)*(-1) -> 1; (-3)*5 -> 16'hFFF1. Each has done latency = k+1 with k from |a|.
- Handshake: pulse start during RUN with different operands -> ignored, first result correct. Assert start in the done cycle with a=255, b=255, unsigned -> accepted, product=65025 after 9 more cycles.
- Reset mid-RUN: start a=200, b=3, assert rst at cycle 3 -> next cycle busy=0, done=0, product=0; no done pulse follows. A fresh op 6*7 -> 42.
- Random sweep: 2000 random (a, b, signed_mode) with random start gaps vs reference model -> product and latency match for every op; done is never wider than 1 cycle.
